// File: rtl/tof_interval_meter.sv
// tof_interval_meter
//   Time-of-flight interval counter for the rangefinder receive chain.
//   A fire strobe (start) sampled in IDLE clears the cycle counter; the
//   counter then runs through a blanking window, where triggers from the
//   threshold stage are ignored to reject direct emitter crosstalk, and
//   into the measurement window, where the first trigger stops it. With no
//   echo by TIMEOUT edges a timeout result is produced instead. Results
//   are offered on a valid/ready handshake and held until accepted.
//
//   Optional build macro TOF_AVG_EN: results are accumulated over groups
//   of 2^AVG_LOG2 measurements and only the group average is presented,
//   with tof_timeout set if any measurement in the group timed out.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   emitter fire strobe, sampled only in IDLE
//   trigger     in   single-cycle stop pulse from the trigger generator
//   busy        out  high whenever the state is not IDLE
//   tof_count   out  measured interval in clock edges (CNT_W bits)
//   tof_timeout out  result is a timeout (no echo)
//   tof_valid   out  result available
//   tof_ready   in   consumer accepts result
module tof_interval_meter #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned BLANK_CYCLES = 32,
  parameter int unsigned TIMEOUT      = 50000,
  parameter int unsigned AVG_LOG2     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             trigger,
  output logic             busy,
  output logic [CNT_W-1:0] tof_count,
  output logic             tof_timeout,
  output logic             tof_valid,
  input  logic             tof_ready
);

  // The counter must reach TIMEOUT without wrapping, and blanking must end
  // before the timeout edge.
  if (BLANK_CYCLES >= TIMEOUT || (TIMEOUT >> CNT_W) != 0 ||
      CNT_W + AVG_LOG2 > 64) begin : g_param_check
    $error("tof_interval_meter: invalid parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BLANK, MEASURE, DONE} state_t;

  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] TMO_VAL   = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;
  logic             valid_q, valid_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             stop;
  logic [CNT_W-1:0] result;
  logic             result_to;

`ifdef TOF_AVG_EN
  localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
  localparam int unsigned GRP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic             to_acc_q, to_acc_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    valid_d   = valid_q;
    cnt_inc   = cnt_q + CNT_W'(1);
    stop      = 1'b0;
    result    = '0;
    result_to = 1'b0;
`ifdef TOF_AVG_EN
    acc_d    = acc_q;
    grp_d    = grp_q;
    to_acc_d = to_acc_q;
    acc_sum  = '0;
`endif

    // cnt_inc is the index k of the edge being evaluated (start edge is E0).
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = (BLANK_CYCLES == 0) ? MEASURE : BLANK;
        end
      end
      BLANK: begin
        cnt_d = cnt_inc;
        if (cnt_inc == BLANK_END) state_d = MEASURE;
      end
      MEASURE: begin
        cnt_d = cnt_inc;
        // Trigger takes priority over a coincident timeout.
        if (trigger) begin
          stop      = 1'b1;
          result    = cnt_inc;
          result_to = 1'b0;
        end else if (cnt_inc == TMO_VAL) begin
          stop      = 1'b1;
          result    = TMO_VAL;
          result_to = 1'b1;
        end
      end
      DONE: begin
        if (valid_q && tof_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
`ifdef TOF_AVG_EN
          acc_d    = '0;
          grp_d    = '0;
          to_acc_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef TOF_AVG_EN
    if (stop) begin
      acc_sum = acc_q + ACC_W'(result);
      if (grp_q == GRP_LAST) begin
        count_d   = CNT_W'(acc_sum >> AVG_LOG2);
        timeout_d = to_acc_q | result_to;
        valid_d   = 1'b1;
        state_d   = DONE;
      end else begin
        acc_d    = acc_sum;
        grp_d    = grp_q + GRP_W'(1);
        to_acc_d = to_acc_q | result_to;
        state_d  = IDLE;
      end
    end
`else
    if (stop) begin
      count_d   = result;
      timeout_d = result_to;
      valid_d   = 1'b1;
      state_d   = DONE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
`ifdef TOF_AVG_EN
      acc_q    <= '0;
      grp_q    <= '0;
      to_acc_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
`ifdef TOF_AVG_EN
      acc_q    <= acc_d;
      grp_q    <= grp_d;
      to_acc_q <= to_acc_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign tof_count   = count_q;
  assign tof_timeout = timeout_q;
  assign tof_valid   = valid_q;

endmodule

// File: tb/tb_tof_interval_meter.sv
// tb_tof_interval_meter
//   Directed bench for tof_interval_meter. Expected results are pushed to a
//   scoreboard queue when a measurement is launched and popped when the DUT
//   presents tof_valid. TIMEOUT is reduced to keep run time short; edge
//   numbering follows the start edge E0. Build with TOF_AVG_EN defined to
//   exercise the averaging variant.
module tb_tof_interval_meter;

  localparam int CNT_W    = 16;
  localparam int BLANK    = 32;
  localparam int TMO      = 1000;
  localparam int AVG_LOG2 = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             trigger = 1'b0;
  logic             tof_ready = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] tof_count;
  logic             tof_timeout;
  logic             tof_valid;

  typedef struct packed {
    logic [31:0] cnt;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  tof_interval_meter #(
    .CNT_W       (CNT_W),
    .BLANK_CYCLES(BLANK),
    .TIMEOUT     (TMO),
    .AVG_LOG2    (AVG_LOG2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .trigger    (trigger),
    .busy       (busy),
    .tof_count  (tof_count),
    .tof_timeout(tof_timeout),
    .tof_valid  (tof_valid),
    .tof_ready  (tof_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input int c, input bit t);
    exp_t e;
    e.cnt = c;
    e.to  = t;
    sb.push_back(e);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, tof_valid, 1);
    chk({tag, "_count"}, tof_count, e.cnt);
    chk({tag, "_timeout"}, tof_timeout, e.to);
  endtask

  // Launch a measurement: start at E0, triggers at edges ta and tb (-1 for
  // none), optional spurious start pulses while busy. Returns the edge after
  // which a result appeared (or the state went idle), -1 if none in budget.
  task automatic meas(input string tag, input int ta, input int tb,
                      input bit spur, output int stop_k);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    stop_k = -1;
    for (int k = 1; k <= TMO + 5; k++) begin
      trigger = (k == ta) || (k == tb);
      start   = spur && (k % 5 == 2);
      tick();
      trigger = 1'b0;
      start   = 1'b0;
      if (tof_valid || !busy) begin
        stop_k = k;
        break;
      end
    end
  endtask

  task automatic handshake(input string tag, input bit start_on_hs);
    tof_ready = 1'b1;
    start     = start_on_hs;
    tick();
    tof_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_hs_valid"}, tof_valid, 0);
    chk({tag, "_hs_busy"}, busy, 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, tof_valid, 0);
    chk({tag, "_count"}, tof_count, 0);
    chk({tag, "_timeout"}, tof_timeout, 0);
  endtask

`ifdef TOF_AVG_EN
  // One group of four measurements; trigger -1 means that one times out.
  task automatic avg_group(input string tag, input int t0, input int t1,
                           input int t2, input int t3, input int exp_c,
                           input bit exp_to);
    int trig[4];
    int k;
    trig[0] = t0; trig[1] = t1; trig[2] = t2; trig[3] = t3;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect_result(exp_c, exp_to);
      meas(tag, trig[i], -1, 1'b0, k);
      chk({tag, "_stop_edge"}, k, (trig[i] < 0) ? TMO : trig[i]);
      if (i < 3) begin
        chk({tag, "_partial_valid"}, tof_valid, 0);
        chk({tag, "_partial_busy"}, busy, 0);
      end else begin
        check_result(tag);
      end
    end
    handshake(tag, 1'b0);
  endtask
`endif

  initial begin
    int k;
    rst_n = 1'b0;
    tick();
    tick();
    reset_checks("reset");
    rst_n = 1'b1;
    tof_ready = 1'b1;
    tick();
    tick();
    tof_ready = 1'b0;
    chk("ready_idle_valid", tof_valid, 0);
    chk("ready_idle_busy", busy, 0);

`ifdef TOF_AVG_EN
    avg_group("avg_hit", 100, 101, 102, 104, 101, 1'b0);
    avg_group("avg_tmo", 100, 100, 100, -1, (300 + TMO) >> 2, 1'b1);

    // Reset partway through a group discards the partial accumulation.
    meas("avg_pre", 200, -1, 1'b0, k);
    meas("avg_pre", 200, -1, 1'b0, k);
    rst_n = 1'b0;
    #1;
    reset_checks("avg_reset");
    tick();
    rst_n = 1'b1;
    tick();
    avg_group("avg_post", 40, 40, 40, 44, 41, 1'b0);
`else
    // Plain hit
    expect_result(100, 1'b0);
    meas("hit", 100, -1, 1'b0, k);
    chk("hit_stop_edge", k, 100);
    check_result("hit");
    handshake("hit", 1'b0);

    // Trigger inside blanking ignored, second one measured; spurious starts
    expect_result(200, 1'b0);
    meas("blank", 10, 200, 1'b1, k);
    chk("blank_stop_edge", k, 200);
    check_result("blank");
    handshake("blank", 1'b0);

    // Last blanked edge: ignored, so the measurement times out
    expect_result(TMO, 1'b1);
    meas("blank_last", BLANK, -1, 1'b0, k);
    chk("blank_last_stop_edge", k, TMO);
    check_result("blank_last");
    handshake("blank_last", 1'b0);

    // Earliest accepted edge
    expect_result(BLANK + 1, 1'b0);
    meas("first_hit", BLANK + 1, -1, 1'b0, k);
    chk("first_hit_stop_edge", k, BLANK + 1);
    check_result("first_hit");
    handshake("first_hit", 1'b0);

    // Trigger coincident with timeout wins
    expect_result(TMO, 1'b0);
    meas("tmo_trig", TMO, -1, 1'b0, k);
    chk("tmo_trig_stop_edge", k, TMO);
    check_result("tmo_trig");
    handshake("tmo_trig", 1'b0);

    // Backpressure: outputs held, triggers and starts in DONE ignored
    expect_result(77, 1'b0);
    meas("bp", 77, -1, 1'b1, k);
    chk("bp_stop_edge", k, 77);
    check_result("bp");
    for (int i = 0; i < 20; i++) begin
      start   = (i % 2 == 0);
      trigger = (i % 3 == 0);
      tick();
      start   = 1'b0;
      trigger = 1'b0;
      chk("bp_hold_count", tof_count, 77);
      chk("bp_hold_timeout", tof_timeout, 0);
      chk("bp_hold_valid", tof_valid, 1);
      chk("bp_hold_busy", busy, 1);
    end
    // Start on the handshake edge is dropped; the next edge accepts it
    handshake("bp", 1'b1);
    expect_result(45, 1'b0);
    meas("after_hs", 45, -1, 1'b0, k);
    chk("after_hs_stop_edge", k, 45);
    check_result("after_hs");
    handshake("after_hs", 1'b0);

    // Asynchronous reset partway through a measurement
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 40; i++) tick();
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    expect_result(150, 1'b0);
    meas("post_reset", 150, -1, 1'b0, k);
    chk("post_reset_stop_edge", k, 150);
    check_result("post_reset");
    handshake("post_reset", 1'b0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
